// File: rtl/ifft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ifft_pkg
// Description : Shared constants for the serial 8-point inverse FFT.
//               Provides the Q2.14 twiddle tables, default widths and the
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ifft_pkg;

   localparam int DEF_IN_W   = 19;
   localparam int DEF_OUT_W  = 16;
   localparam int DEF_COEF_W = 16;
   localparam int DEF_ACC_W  = 40;

   // cos(2*pi*m/8) and sin(2*pi*m/8) in Q2.14, m = 0..7
   localparam logic signed [DEF_COEF_W-1:0] COS_Q14 [0:7] = '{
      16'sh4000,  16'sh2D41,  16'sh0000, -16'sh2D41,
     -16'sh4000, -16'sh2D41,  16'sh0000,  16'sh2D41};
   localparam logic signed [DEF_COEF_W-1:0] SIN_Q14 [0:7] = '{
      16'sh0000,  16'sh2D41,  16'sh4000,  16'sh2D41,
      16'sh0000, -16'sh2D41, -16'sh4000, -16'sh2D41};

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_CALC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ifft_cmac.sv
`default_nettype none
// ============================================================================
// Module      : ifft_cmac
// Description : Registered complex multiply followed by a complex accumulate.
//               Stage 1 registers x*w, stage 2 adds it into the accumulator,
//               restarting from zero when the product was issued with clr.
// Ports       : clk, rstn        clock, async active-low reset
//               en, clr          issue a product / product starts a new sum
//               xr, xi           complex sample
//               wr, wi           complex twiddle (Q2.14)
//               acc_re, acc_im   running sums
// Revision    : 1.0 - initial release
// ============================================================================
module ifft_cmac #(
   parameter int IN_W   = 19,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic                     clr,
   input  logic signed [IN_W-1:0]   xr,
   input  logic signed [IN_W-1:0]   xi,
   input  logic signed [COEF_W-1:0] wr,
   input  logic signed [COEF_W-1:0] wi,
   output logic signed [ACC_W-1:0]  acc_re,
   output logic signed [ACC_W-1:0]  acc_im
);

   logic signed [ACC_W-1:0] prod_re;
   logic signed [ACC_W-1:0] prod_im;
   logic                    prod_vld;
   logic                    prod_clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prod_re  <= '0;
         prod_im  <= '0;
         prod_vld <= 1'b0;
         prod_clr <= 1'b0;
         acc_re   <= '0;
         acc_im   <= '0;
      end else begin
         prod_vld <= en;
         if (en) begin
            prod_re  <= ACC_W'(xr) * ACC_W'(wr) - ACC_W'(xi) * ACC_W'(wi);
            prod_im  <= ACC_W'(xr) * ACC_W'(wi) + ACC_W'(xi) * ACC_W'(wr);
            prod_clr <= clr;
         end
         if (prod_vld) begin
            acc_re <= (prod_clr ? '0 : acc_re) + prod_re;
            acc_im <= (prod_clr ? '0 : acc_im) + prod_im;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ifft8_serial.sv
`default_nettype none
// ============================================================================
// Module      : ifft8_serial
// Description : Serial 8-point inverse FFT with 1/8 scaling. Loads 8 bins,
//               then computes each time sample with one time-shared complex
//               MAC (8 issue cycles + 2 drain cycles) and holds it until
//               accepted downstream.
// Ports       : clk, rstn              clock, async active-low reset
//               in_valid/in_ready      bin handshake, in_data = {imag,real}
//               out_valid/out_ready    sample handshake, out_data = {imag,real}
//               out_last               marks sample n=7
//               out_sat                sample clipped in either component
// Revision    : 1.0 - initial release
// ============================================================================
module ifft8_serial
   import ifft_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*IN_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*OUT_W-1:0]   out_data,
   output logic                 out_last,
   output logic                 out_sat
);

   // 1/8 scaling plus removal of the Q14 twiddle gain
   localparam int                      SHIFT = 17;
   localparam logic signed [ACC_W-1:0] RND   = ACC_W'(65536);
   localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   state_t                  state;
   logic [2:0]              k;
   logic [2:0]              n;
   logic [3:0]              cyc;
   logic signed [IN_W-1:0]  bin_re [0:7];
   logic signed [IN_W-1:0]  bin_im [0:7];
   logic signed [ACC_W-1:0] acc_re;
   logic signed [ACC_W-1:0] acc_im;
   logic [2:0]              m;
   logic                    issue;
   logic [OUT_W:0]          y_re;
   logic [OUT_W:0]          y_im;

   // Returns {clipped, value}
   function automatic logic [OUT_W:0] rnd_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = (a + RND) >>> SHIFT;
      if (s > ACC_W'(Y_MAX))
         return {1'b1, Y_MAX};
      else if (s < ACC_W'(Y_MIN))
         return {1'b1, Y_MIN};
      else
         return {1'b0, s[OUT_W-1:0]};
   endfunction

   // cyc 0..7 issues bin cyc; 8 and 9 let the two MAC stages drain
   assign issue = (state == S_CALC) && !cyc[3];
   // 3-bit product wraps, giving (n*k) mod 8 directly
   assign m     = n * cyc[2:0];

   ifft_cmac #(
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_cmac (
      .clk    (clk),
      .rstn   (rstn),
      .en     (issue),
      .clr    (cyc[2:0] == 3'd0),
      .xr     (bin_re[cyc[2:0]]),
      .xi     (bin_im[cyc[2:0]]),
      .wr     (COEF_W'(COS_Q14[m])),
      .wi     (COEF_W'(SIN_Q14[m])),
      .acc_re (acc_re),
      .acc_im (acc_im)
   );

   assign y_re = rnd_sat(acc_re);
   assign y_im = rnd_sat(acc_im);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_LOAD;
         in_ready  <= 1'b0;
         k         <= 3'd0;
         n         <= 3'd0;
         cyc       <= 4'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sat   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            bin_re[i] <= '0;
            bin_im[i] <= '0;
         end
      end else begin
         case (state)
            S_LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  bin_re[k] <= in_data[IN_W-1:0];
                  bin_im[k] <= in_data[2*IN_W-1:IN_W];
                  k         <= k + 3'd1;
                  if (k == 3'd7) begin
                     state    <= S_CALC;
                     in_ready <= 1'b0;
                     n        <= 3'd0;
                     cyc      <= 4'd0;
                  end
               end
            end
            S_CALC: begin
               cyc <= cyc + 4'd1;
               if (cyc == 4'd9) begin
                  state     <= S_HOLD;
                  out_valid <= 1'b1;
                  out_data  <= {y_im[OUT_W-1:0], y_re[OUT_W-1:0]};
                  out_last  <= (n == 3'd7);
                  out_sat   <= y_re[OUT_W] | y_im[OUT_W];
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (n == 3'd7) begin
                     state    <= S_LOAD;
                     in_ready <= 1'b1;
                     k        <= 3'd0;
                  end else begin
                     state <= S_CALC;
                     n     <= n + 3'd1;
                     cyc   <= 4'd0;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifft8_serial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ifft8_serial
// Description : Self-checking bench for ifft8_serial. Table of directed
//               frames with hand-computed outputs, plus round trip,
//               backpressure and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft8_serial;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [37:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_sat;

   always #5 clk = ~clk;

   ifft8_serial dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sat   (out_sat)
   );

   typedef struct packed {
      logic [7:0][18:0] xr;
      logic [7:0][18:0] xi;
      logic [7:0][15:0] yr;
      logic [7:0][15:0] yi;
      logic [7:0]       sat;
   } vec_t;

   localparam int NV = 7;
   vec_t tv [NV];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_ref = 0;

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp, input int tol);
      total++;
      if (act > exp + tol || act < exp - tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic send_frame(input vec_t v, input string tag);
      int  k;
      int  g;
      bit  rdy;
      k = 0;
      g = 0;
      while (k < 8 && g < 64) begin
         in_valid = 1'b1;
         in_data  = {v.xi[k], v.xr[k]};
         rdy      = in_ready;
         tick();
         if (rdy) k++;
         g++;
      end
      in_valid = 1'b0;
      t_ref    = cyc;
      chk({tag, " bins accepted"}, k, 8, 0);
   endtask

   task automatic recv_frame(input vec_t v, input int tol, input int stall_n,
                             input bit junk, input int stop_n, input string tag);
      for (int n = 0; n < stop_n; n++) begin
         int          w;
         int          irb;
         logic [31:0] held;
         bit          stab;
         string       t;
         t   = $sformatf("%s n%0d", tag, n);
         w   = 0;
         irb = 0;
         while (!out_valid && w < 40) begin
            if (in_ready) irb++;
            if (junk) begin
               in_valid = 1'b1;
               in_data  = 38'({$urandom(), $urandom()});
            end
            tick();
            w++;
         end
         chk({t, " latency"}, cyc - t_ref, 10, 0);
         chk({t, " re"}, $signed(out_data[15:0]), $signed(v.yr[n]), tol);
         chk({t, " im"}, $signed(out_data[31:16]), $signed(v.yi[n]), tol);
         chk({t, " sat"}, int'(out_sat), int'(v.sat[n]), 0);
         chk({t, " last"}, int'(out_last), int'(n == 7), 0);
         chk({t, " in_ready busy"}, irb + int'(in_ready), 0, 0);
         if (n == stall_n) begin
            held = out_data;
            stab = 1'b1;
            for (int s = 0; s < 5; s++) begin
               tick();
               if (!out_valid || out_data !== held || out_last !== (n == 7)) stab = 1'b0;
            end
            chk({t, " stall stable"}, int'(stab), 1, 0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         t_ref     = cyc;
         chk({t, " valid drop"}, int'(out_valid), 0, 0);
      end
      if (stop_n == 8) chk({tag, " in_ready after last"}, int'(in_ready), 1, 0);
   endtask

   initial begin
      int   er [8];
      int   ei [8];
      int   x  [8];
      real  ar;
      real  ai;
      real  ang;
      vec_t rt;

      er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
      ei = '{0, 707, 1000, 707, 0, -707, -1000, -707};
      for (int i = 0; i < NV; i++) tv[i] = '0;
      // impulse at bin 0
      tv[0].xr[0] = 19'd800;
      for (int n = 0; n < 8; n++) tv[0].yr[n] = 16'd100;
      // single tone at bin 1
      tv[1].xr[1] = 19'd8000;
      for (int n = 0; n < 8; n++) begin
         tv[1].yr[n] = 16'(er[n]);
         tv[1].yi[n] = 16'(ei[n]);
      end
      // full-scale positive DC: clips at n=0 only
      for (int k = 0; k < 8; k++) tv[2].xr[k] = 19'd262143;
      tv[2].yr[0]  = 16'h7FFF;
      tv[2].sat[0] = 1'b1;
      // full-scale negative DC
      for (int k = 0; k < 8; k++) tv[3].xr[k] = 19'h40000;
      tv[3].yr[0]  = 16'h8000;
      tv[3].sat[0] = 1'b1;
      // Nyquist bin: alternating sign, negative half rounds to -100
      tv[4].xr[4] = 19'd800;
      for (int n = 0; n < 8; n++) tv[4].yr[n] = (n % 2 == 0) ? 16'd100 : 16'hFF9C;
      // purely imaginary DC
      tv[5].xi[0] = 19'h7FCE0;  // -800
      for (int n = 0; n < 8; n++) tv[5].yi[n] = 16'hFF9C;
      // imaginary tone at bin 2: y = 1000*(-sin(pi*n/2), cos(pi*n/2))
      tv[6].xi[2] = 19'd8000;
      for (int n = 0; n < 8; n++) begin
         case (n % 4)
            0: tv[6].yi[n] = 16'd1000;
            1: tv[6].yr[n] = 16'hFC18;  // -1000
            2: tv[6].yi[n] = 16'hFC18;
            default: tv[6].yr[n] = 16'd1000;
         endcase
      end

      // reset state
      repeat (3) @(negedge clk);
      chk("reset in_ready", int'(in_ready), 0, 0);
      chk("reset out_valid", int'(out_valid), 0, 0);
      chk("reset out_data", int'(out_data), 0, 0);
      chk("reset out_last", int'(out_last), 0, 0);
      chk("reset out_sat", int'(out_sat), 0, 0);
      rstn = 1'b1;
      tick();
      chk("in_ready after release", int'(in_ready), 1, 0);

      // directed table; vector 1 also carries backpressure and ignored input
      for (int i = 0; i < NV; i++) begin
         send_frame(tv[i], $sformatf("v%0d", i));
         recv_frame(tv[i], 0, (i == 1) ? 3 : -1, i == 1, 8, $sformatf("v%0d", i));
      end

      // round trip: real forward FFT8 of random samples, then inverse
      rt = '0;
      for (int n = 0; n < 8; n++) begin
         x[n]     = int'($urandom_range(60000, 0)) - 30000;
         rt.yr[n] = 16'(x[n]);
      end
      for (int k = 0; k < 8; k++) begin
         ar = 0.0;
         ai = 0.0;
         for (int n = 0; n < 8; n++) begin
            ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
            ar  = ar + real'(x[n]) * $cos(ang);
            ai  = ai - real'(x[n]) * $sin(ang);
         end
         rt.xr[k] = 19'(int'(ar));
         rt.xi[k] = 19'(int'(ai));
      end
      send_frame(rt, "rt");
      recv_frame(rt, 1, -1, 1'b0, 8, "rt");

      // reset while computing sample 4
      send_frame(tv[0], "rst");
      recv_frame(tv[0], 0, -1, 1'b0, 4, "rst");
      repeat (3) tick();
      rstn = 1'b0;
      #1;
      chk("mid reset out_valid", int'(out_valid), 0, 0);
      chk("mid reset out_data", int'(out_data), 0, 0);
      chk("mid reset in_ready", int'(in_ready), 0, 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("post reset in_ready", int'(in_ready), 1, 0);
      send_frame(tv[0], "after_rst");
      recv_frame(tv[0], 0, -1, 1'b0, 8, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
